// File: rtl/mem_bus_ctrl.sv
// Instruction fetcher for a 256x4 nibble RAM: two reads per 8-bit instruction, held until accepted.
// Optional single-cycle load/store port enabled by defining MBC_DATA_PORT_EN.
module mem_bus_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] mem_addr,
  inout  wire  [3:0] mem_data,
  output logic       mem_we,
  input  logic       fetch_ready,
  output logic       instr_valid,
  output logic [7:0] instr,
  output logic [7:0] instr_addr,
  input  logic       jump_en,
  input  logic [7:0] jump_addr,
  input  logic       dreq,
  input  logic       dwe,
  input  logic [7:0] daddr,
  input  logic [3:0] dwdata,
  output logic       dack,
  output logic [3:0] drdata
);

`ifdef MBC_DATA_PORT_EN
  localparam bit DataPortEn = 1'b1;
`else
  localparam bit DataPortEn = 1'b0;
`endif

  typedef enum logic [1:0] {FETCH_HI, FETCH_LO, HOLD, DATA} state_t;

  state_t     state;
  state_t     state_next;
  logic       handshake;
  logic [7:0] pc;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH_HI;
    else        state <= state_next;
  end

  // A pending data access wins over the next fetch, but only at the handshake.
  always_comb begin
    state_next = state;
    handshake  = 1'b0;
    case (state)
      FETCH_HI: state_next = FETCH_LO;
      FETCH_LO: state_next = HOLD;
      HOLD: begin
        if (fetch_ready) begin
          handshake  = 1'b1;
          state_next = (DataPortEn && dreq) ? DATA : FETCH_HI;
        end
      end
      DATA:     state_next = FETCH_HI;
      default:  state_next = FETCH_HI;
    endcase
  end

  assign mem_addr = (state == DATA) ? daddr : pc;

  // Write strobe and bus drive are gated by rst_n so a reset mid-store never writes or contends.
  assign mem_we   = DataPortEn && rst_n && (state == DATA) && dwe;
  assign mem_data = mem_we ? dwdata : 4'bz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= 8'h00;
      instr_addr  <= 8'h00;
      instr_valid <= 1'b0;
      dack        <= 1'b0;
      drdata      <= 4'h0;
    end else begin
      dack <= 1'b0;
      case (state)
        FETCH_HI: begin
          instr[7:4] <= mem_data;
          instr_addr <= pc;
          pc         <= pc + 8'd1;
        end
        FETCH_LO: begin
          instr[3:0]  <= mem_data;
          pc          <= pc + 8'd1;
          instr_valid <= 1'b1;
        end
        HOLD: begin
          if (handshake) begin
            instr_valid <= 1'b0;
            if (jump_en) pc <= jump_addr;
          end
        end
        DATA: begin
          dack <= DataPortEn;
          if (DataPortEn && !dwe) drdata <= mem_data;
        end
        default: ;
      endcase
    end
  end

endmodule
